// File: rtl/vuart_mc.sv
// Multi-channel single-clock virtual UART: per-channel RX (host->dev) and TX (dev->host) FIFOs
// behind two zero-wait APB ports. Optional idle timeout on RX enabled by VUART_MC_RX_TIMEOUT_EN.
module vuart_mc #(
  parameter int N_CH     = 2,
  parameter int RX_DEPTH = 8,
  parameter int TX_DEPTH = 16,
  parameter int W_DATA   = 8,
  parameter int RX_TMO   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH-1:0]   hostconn,
  output logic [N_CH-1:0]   irq,
  input  logic              host_psel,
  input  logic              host_penable,
  input  logic              host_pwrite,
  input  logic [7:0]        host_paddr,
  input  logic [31:0]       host_pwdata,
  output logic [31:0]       host_prdata,
  output logic              host_pready,
  output logic              host_pslverr,
  input  logic              dev_psel,
  input  logic              dev_penable,
  input  logic              dev_pwrite,
  input  logic [7:0]        dev_paddr,
  input  logic [31:0]       dev_pwdata,
  output logic [31:0]       dev_prdata,
  output logic              dev_pready,
  output logic              dev_pslverr
);

  localparam int RXA = $clog2(RX_DEPTH);
  localparam int RXL = $clog2(RX_DEPTH + 1);
  localparam int TXA = $clog2(TX_DEPTH);
  localparam int TXL = $clog2(TX_DEPTH + 1);

  typedef enum logic [1:0] {
    REG_STAT    = 2'd0,
    REG_FIFO    = 2'd1,
    REG_IRQCTRL = 2'd2,
    REG_RSVD    = 2'd3
  } reg_e;

  logic [2:0] w_h_ch, w_d_ch;
  reg_e       w_h_reg, w_d_reg;
  logic       w_h_err, w_d_err;

  assign w_h_ch  = host_paddr[6:4];
  assign w_d_ch  = dev_paddr[6:4];
  assign w_h_reg = reg_e'(host_paddr[3:2]);
  assign w_d_reg = reg_e'(dev_paddr[3:2]);
  // IRQCTRL belongs to the device side only.
  assign w_h_err = (int'(w_h_ch) >= N_CH) || (w_h_reg == REG_RSVD) || (w_h_reg == REG_IRQCTRL);
  assign w_d_err = (int'(w_d_ch) >= N_CH) || (w_d_reg == REG_RSVD);

  assign host_pready  = 1'b1;
  assign dev_pready   = 1'b1;
  assign host_pslverr = host_psel && host_penable && w_h_err;
  assign dev_pslverr  = dev_psel && dev_penable && w_d_err;

  logic [W_DATA-1:0] r_rx_mem [N_CH][RX_DEPTH];
  logic [W_DATA-1:0] r_tx_mem [N_CH][TX_DEPTH];
  logic [RXA-1:0]    r_rx_wp  [N_CH];
  logic [RXA-1:0]    r_rx_rp  [N_CH];
  logic [RXL-1:0]    r_rx_cnt [N_CH];
  logic [TXA-1:0]    r_tx_wp  [N_CH];
  logic [TXA-1:0]    r_tx_rp  [N_CH];
  logic [TXL-1:0]    r_tx_cnt [N_CH];
  logic [1:0]        r_tx_lvl [N_CH];
  logic [7:0]        r_rx_thresh [N_CH];
  logic [N_CH-1:0]   r_h_ovf, r_d_ovf, r_rx_en, r_tx_en;

  logic [N_CH-1:0] w_rx_push, w_rx_pop, w_rx_full, w_tx_push, w_tx_pop, w_tx_full;
  logic [N_CH-1:0] w_h_ovf_set, w_d_ovf_set, w_h_ovf_clr, w_d_ovf_clr;
  logic [N_CH-1:0] w_ctrl_wr, w_irq_nxt, w_tmo;

  always_comb begin
    logic       h_sel, d_sel, rx_req, tx_req, tx_cond;
    logic [8:0] thr;
    h_sel = 1'b0; d_sel = 1'b0; rx_req = 1'b0; tx_req = 1'b0; tx_cond = 1'b0; thr = '0;
    w_rx_push = '0; w_rx_pop = '0; w_rx_full = '0; w_tx_push = '0; w_tx_pop = '0; w_tx_full = '0;
    w_h_ovf_set = '0; w_d_ovf_set = '0; w_h_ovf_clr = '0; w_d_ovf_clr = '0;
    w_ctrl_wr = '0; w_irq_nxt = '0;
    for (int c = 0; c < N_CH; c++) begin
      h_sel = host_psel && host_penable && !w_h_err && (w_h_ch == 3'(c));
      d_sel = dev_psel && dev_penable && !w_d_err && (w_d_ch == 3'(c));
      w_rx_full[c] = (r_rx_cnt[c] == RXL'(RX_DEPTH));
      w_tx_full[c] = (r_tx_cnt[c] == TXL'(TX_DEPTH));
      w_rx_pop[c]  = d_sel && !dev_pwrite && (w_d_reg == REG_FIFO) && (r_rx_cnt[c] != '0);
      w_tx_pop[c]  = h_sel && !host_pwrite && (w_h_reg == REG_FIFO) && (r_tx_cnt[c] != '0);
      rx_req = h_sel && host_pwrite && (w_h_reg == REG_FIFO);
      tx_req = d_sel && dev_pwrite && (w_d_reg == REG_FIFO);
      // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
      w_rx_push[c]   = rx_req && (!w_rx_full[c] || w_rx_pop[c]);
      w_tx_push[c]   = tx_req && (!w_tx_full[c] || w_tx_pop[c]);
      w_h_ovf_set[c] = rx_req && !w_rx_push[c];
      w_d_ovf_set[c] = tx_req && !w_tx_push[c];
      w_h_ovf_clr[c] = h_sel && host_pwrite && (w_h_reg == REG_STAT) && host_pwdata[3];
      w_d_ovf_clr[c] = d_sel && dev_pwrite && (w_d_reg == REG_STAT) && dev_pwdata[3];
      w_ctrl_wr[c]   = d_sel && dev_pwrite && (w_d_reg == REG_IRQCTRL);

      thr = 9'(r_rx_thresh[c]);
      if (thr == '0) thr = 9'd1;
      else if (thr > 9'(RX_DEPTH)) thr = 9'(RX_DEPTH);
      case (r_tx_lvl[c])
        2'd0: tx_cond = (r_tx_cnt[c] == '0);
        2'd1: tx_cond = (r_tx_cnt[c] < TXL'(TX_DEPTH / 2));
        2'd2: tx_cond = (r_tx_cnt[c] < TXL'(3 * TX_DEPTH / 4));
        2'd3: tx_cond = !w_tx_full[c];
      endcase
      w_irq_nxt[c] = (r_rx_en[c] && ((9'(r_rx_cnt[c]) >= thr) || w_tmo[c])) ||
                     (r_tx_en[c] && tx_cond);
    end
  end

  // NOTE: FIFO storage carries no reset; the pointers and counts define which entries are valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < N_CH; c++) begin
      if (w_rx_push[c]) r_rx_mem[c][r_rx_wp[c]] <= host_pwdata[W_DATA-1:0];
      if (w_tx_push[c]) r_tx_mem[c][r_tx_wp[c]] <= dev_pwdata[W_DATA-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        r_rx_wp[c] <= '0; r_rx_rp[c] <= '0; r_rx_cnt[c] <= '0;
        r_tx_wp[c] <= '0; r_tx_rp[c] <= '0; r_tx_cnt[c] <= '0;
        r_tx_lvl[c] <= '0; r_rx_thresh[c] <= '0;
      end
      r_h_ovf <= '0; r_d_ovf <= '0; r_rx_en <= '0; r_tx_en <= '0;
      irq     <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_rx_push[c]) r_rx_wp[c] <= r_rx_wp[c] + RXA'(1);
        if (w_rx_pop[c])  r_rx_rp[c] <= r_rx_rp[c] + RXA'(1);
        if (w_rx_push[c] && !w_rx_pop[c])      r_rx_cnt[c] <= r_rx_cnt[c] + RXL'(1);
        else if (!w_rx_push[c] && w_rx_pop[c]) r_rx_cnt[c] <= r_rx_cnt[c] - RXL'(1);
        if (w_tx_push[c]) r_tx_wp[c] <= r_tx_wp[c] + TXA'(1);
        if (w_tx_pop[c])  r_tx_rp[c] <= r_tx_rp[c] + TXA'(1);
        if (w_tx_push[c] && !w_tx_pop[c])      r_tx_cnt[c] <= r_tx_cnt[c] + TXL'(1);
        else if (!w_tx_push[c] && w_tx_pop[c]) r_tx_cnt[c] <= r_tx_cnt[c] - TXL'(1);
        if (w_h_ovf_set[c])      r_h_ovf[c] <= 1'b1;
        else if (w_h_ovf_clr[c]) r_h_ovf[c] <= 1'b0;
        if (w_d_ovf_set[c])      r_d_ovf[c] <= 1'b1;
        else if (w_d_ovf_clr[c]) r_d_ovf[c] <= 1'b0;
        if (w_ctrl_wr[c]) begin
          r_rx_en[c]     <= dev_pwdata[0];
          r_tx_en[c]     <= dev_pwdata[1];
          r_tx_lvl[c]    <= dev_pwdata[3:2];
          r_rx_thresh[c] <= dev_pwdata[15:8];
        end
      end
      irq <= w_irq_nxt;
    end
  end

`ifdef VUART_MC_RX_TIMEOUT_EN
  localparam int TMW = $clog2(RX_TMO + 1);
  logic [TMW-1:0] r_tmo_cnt [N_CH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) r_tmo_cnt[c] <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        if (w_rx_push[c] || w_rx_pop[c] || (r_rx_cnt[c] == '0)) r_tmo_cnt[c] <= '0;
        else if (r_tmo_cnt[c] != TMW'(RX_TMO))                   r_tmo_cnt[c] <= r_tmo_cnt[c] + TMW'(1);
      end
    end
  end

  always_comb begin
    w_tmo = '0;
    for (int c = 0; c < N_CH; c++) w_tmo[c] = (r_tmo_cnt[c] == TMW'(RX_TMO));
  end
`else
  assign w_tmo = '0;
`endif

  // Read data is relative to the reading port: the host receives from TX, the device from RX.
  always_comb begin
    host_prdata = '0;
    dev_prdata  = '0;
    for (int c = 0; c < N_CH; c++) begin
      if (host_psel && !w_h_err && (w_h_ch == 3'(c))) begin
        case (w_h_reg)
          REG_STAT: begin
            host_prdata[0]         = (r_tx_cnt[c] != '0);
            host_prdata[1]         = !w_rx_full[c];
            host_prdata[2]         = hostconn[c];
            host_prdata[3]         = r_h_ovf[c];
            host_prdata[8 +: TXL]  = r_tx_cnt[c];
            host_prdata[16 +: RXL] = r_rx_cnt[c];
          end
          REG_FIFO: if (r_tx_cnt[c] != '0) begin
            host_prdata[W_DATA-1:0] = r_tx_mem[c][r_tx_rp[c]];
            host_prdata[31]         = 1'b1;
          end
          default: ;
        endcase
      end
      if (dev_psel && !w_d_err && (w_d_ch == 3'(c))) begin
        case (w_d_reg)
          REG_STAT: begin
            dev_prdata[0]         = (r_rx_cnt[c] != '0);
            dev_prdata[1]         = !w_tx_full[c];
            dev_prdata[2]         = hostconn[c];
            dev_prdata[3]         = r_d_ovf[c];
            dev_prdata[4]         = w_tmo[c];
            dev_prdata[8 +: RXL]  = r_rx_cnt[c];
            dev_prdata[16 +: TXL] = r_tx_cnt[c];
          end
          REG_FIFO: if (r_rx_cnt[c] != '0) begin
            dev_prdata[W_DATA-1:0] = r_rx_mem[c][r_rx_rp[c]];
            dev_prdata[31]         = 1'b1;
          end
          REG_IRQCTRL: begin
            dev_prdata[0]    = r_rx_en[c];
            dev_prdata[1]    = r_tx_en[c];
            dev_prdata[3:2]  = r_tx_lvl[c];
            dev_prdata[15:8] = r_rx_thresh[c];
          end
          default: ;
        endcase
      end
    end
  end

  logic w_unused;
  assign w_unused = ^{host_paddr, dev_paddr, host_pwdata, dev_pwdata};

endmodule
